output_send_multi: RTL and testbench
====================================

# output_send_multi

Parametrised output write-back sequencer for the convolution datapath. It is the successor to the fixed six-lane no-pool/pool sender pair. One FSM drives the output-buffer write port (WADDRX/WCEBX) and the per-channel output enables for a programmable pixel count and channel mask. In pool mode it also sequences the comparator (O_COMPARE_*) over a POOL_K-entry window before each pixel's writes. It sits between the layer controller, which issues START, and the output SRAM / max-pool comparator.

## Interface
- NUM_CH, 6: number of output channel lanes; width of OUTPUT_EN_CTRL and CH_MASK.
- ADDR_W, 16: write address width.
- CNT_W, 8: pixel counter width.
- POOL_K, 4: compare cycles per pooled pixel; must be at least 2.

- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request; accepted only in IDLE.
- POOL  in  1  mode, sampled with START: 0 = no-pool, 1 = pool.
- BASE_ADDR  in  ADDR_W  first write address, sampled with START.
- COUNT  in  CNT_W  pixels to emit, sampled with START.
- CH_MASK  in  NUM_CH  enabled channels, sampled with START.
- MODULE_BUSY  in  1  downstream stall.
- WADDRX  out  ADDR_W  write address.
- WCEBX  out  1  write chip enable, active-low.
- OUTPUT_EN  out  1  output write strobe.
- OUTPUT_EN_CTRL  out  NUM_CH  one-hot lane select during a write, otherwise 0.
- O_COMPARE_EN  out  1  comparator active.
- O_COMPARE_MODE  out  1  0 = load first entry, 1 = compare.
- O_COMPARE_SWITCH  out  1  selects the pooled result onto the write data.
- OUTPUT_BUSY  out  1  high from the cycle after START acceptance through the FIN cycle.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CMP, WR, FIN.
- IDLE:
  - START=1 latches POOL, BASE_ADDR, COUNT and CH_MASK, and clears the pixel and compare counters.
  - If COUNT=0 or CH_MASK=0, go to FIN.
  - Otherwise go to CMP if POOL=1, else WR.
- CMP (pool only): lasts POOL_K active cycles.
  - O_COMPARE_EN=1 on each active cycle.
  - O_COMPARE_MODE=0 on the first cycle, 1 on the rest.
  - After the last compare cycle, go to WR.
- WR: one write per set CH_MASK bit, in ascending channel order.
  - Each write cycle drives WCEBX=0, OUTPUT_EN=1, OUTPUT_EN_CTRL=1<<c and WADDRX=current address.
  - The address increments by 1 after each write and wraps modulo 2^ADDR_W.
  - In pool mode, O_COMPARE_SWITCH=1 on every WR cycle.
  - After the last enabled lane, increment the pixel counter.
  - If pixels remain, return to CMP (pool) or repeat WR (no-pool). Otherwise go to FIN.
- FIN: DONE=1 and OUTPUT_BUSY=1 for one cycle, then IDLE.
- Stall: while MODULE_BUSY=1 in CMP or WR:
  - The state, counters and address hold.
  - WCEBX=1, OUTPUT_EN=0, OUTPUT_EN_CTRL=0 and O_COMPARE_EN=0.
  - No write is skipped or duplicated.
  - MODULE_BUSY is ignored in IDLE and FIN.
- START outside IDLE is ignored.
- Reset values: WADDRX=0, WCEBX=1, OUTPUT_EN=0, OUTPUT_EN_CTRL=0, all O_COMPARE_*=0, OUTPUT_BUSY=0, DONE=0. State is IDLE; counters and latched configuration are 0.

## Timing
- All outputs decode registered state and counters only; there is no combinational path from any input to any output.
- START is sampled at edge t. The first CMP or WR cycle is the cycle after edge t.
- Unstalled length: COUNT·(POOL_K·POOL + popcount(CH_MASK)) active cycles, then one FIN cycle.
- COUNT=0 or CH_MASK=0: FIN is the cycle after edge t, with no write or compare.
- Back-to-back operation: a START at the FIN→IDLE edge is not accepted. The earliest accepted START is sampled in the first IDLE cycle.
- RST asserted at any time forces reset values immediately. An in-flight job is abandoned; DONE is not issued.

## Configuration
- OUTPUT_SEND_MULTI_POOL_EN defined: CMP state, compare counter and O_COMPARE_* logic are present, as described above.
- OUTPUT_SEND_MULTI_POOL_EN undefined:
  - POOL is ignored and treated as 0.
  - The CMP state and compare counter are not built.
  - O_COMPARE_EN, O_COMPARE_MODE and O_COMPARE_SWITCH are tied to 0.
  - Every job runs as no-pool.

## Test plan
- No-pool: COUNT=2, CH_MASK=6'b000101, BASE_ADDR=16'h0100, START at edge t. Required: writes (addr/lane) 0100/ch0, 0101/ch2, 0102/ch0, 0103/ch2 in cycles t+1..t+4; DONE in t+5; OUTPUT_BUSY high t+1..t+5.
- Pool: POOL_K=4, COUNT=1, CH_MASK=6'b000011. Required: O_COMPARE_EN in t+1..t+4 with MODE 0,1,1,1; writes in t+5..t+6 with SWITCH=1; DONE in t+7.
- Stall: no-pool, COUNT=3, one lane, MODULE_BUSY high for 3 cycles starting at the second write. Required: addresses BASE, BASE+1, BASE+2 exactly once each; WCEBX=1 throughout the stall; DONE 3 cycles later than unstalled.
- Empty job: COUNT=0, then separately CH_MASK=0. Required: DONE in t+1; WCEBX never low; O_COMPARE_EN never high.
- Address wrap: BASE_ADDR=16'hFFFF, one lane, COUNT=2. Required: WADDRX=FFFF then 0000.
- Reset and START rules: RST pulsed mid-WR. Required: all outputs at reset values in that cycle; FSM in IDLE; no DONE. Separately, a second START issued while busy. Required: ignored, with no change to the address sequence.

Source files
------------

// File: rtl/output_send_multi.sv
// output_send_multi: write-back sequencer for the convolution output buffer.
// Define OUTPUT_SEND_MULTI_POOL_EN to build the max-pool compare phase (CMP).
module output_send_multi #(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8,
  parameter int POOL_K = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              POOL,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  COUNT,
  input  logic [NUM_CH-1:0] CH_MASK,
  input  logic              MODULE_BUSY,
  output logic [ADDR_W-1:0] WADDRX,
  output logic              WCEBX,
  output logic              OUTPUT_EN,
  output logic [NUM_CH-1:0] OUTPUT_EN_CTRL,
  output logic              O_COMPARE_EN,
  output logic              O_COMPARE_MODE,
  output logic              O_COMPARE_SWITCH,
  output logic              OUTPUT_BUSY,
  output logic              DONE
);

  localparam int LANE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_FIN  = 2'd2
`ifdef OUTPUT_SEND_MULTI_POOL_EN
    , S_CMP = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              stall_q, stall_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  pix_q, pix_d, count_q, count_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [LANE_W-1:0] lane_q, lane_d, first_q, first_d;
  logic [LANE_W-1:0] start_first, next_lane;
  logic              next_found;
  logic              wr_act;

`ifdef OUTPUT_SEND_MULTI_POOL_EN
  localparam int CMP_W = $clog2(POOL_K);
  logic             pool_q, pool_d;
  logic [CMP_W-1:0] cmp_q, cmp_d;
`else
  logic unused_pool;
  assign unused_pool = POOL;
`endif

  // Lowest enabled lane of the incoming mask, and the next enabled lane above the current one.
  always_comb begin
    start_first = '0;
    next_lane   = '0;
    next_found  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (CH_MASK[i]) start_first = LANE_W'(i);
      if (mask_q[i] && (i > int'(lane_q))) begin
        next_lane  = LANE_W'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    stall_d = 1'b0;
    addr_d  = addr_q;
    pix_d   = pix_q;
    count_d = count_q;
    mask_d  = mask_q;
    lane_d  = lane_q;
    first_d = first_q;
`ifdef OUTPUT_SEND_MULTI_POOL_EN
    pool_d  = pool_q;
    cmp_d   = cmp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d  = BASE_ADDR;
          count_d = COUNT;
          mask_d  = CH_MASK;
          first_d = start_first;
          lane_d  = start_first;
          pix_d   = '0;
`ifdef OUTPUT_SEND_MULTI_POOL_EN
          pool_d  = POOL;
          cmp_d   = '0;
`endif
          if (COUNT == '0 || CH_MASK == '0) state_d = S_FIN;
`ifdef OUTPUT_SEND_MULTI_POOL_EN
          else if (POOL) state_d = S_CMP;
`endif
          else state_d = S_WR;
        end
      end
      S_WR: begin
        if (!stall_q) begin
          addr_d = addr_q + 1'b1;
          if (next_found) begin
            lane_d = next_lane;
          end else begin
            lane_d = first_q;
            pix_d  = pix_q + 1'b1;
            if (pix_q == count_q - 1'b1) state_d = S_FIN;
`ifdef OUTPUT_SEND_MULTI_POOL_EN
            else if (pool_q) state_d = S_CMP;
`endif
          end
        end
      end
`ifdef OUTPUT_SEND_MULTI_POOL_EN
      S_CMP: begin
        if (!stall_q) begin
          if (cmp_q == CMP_W'(POOL_K - 1)) begin
            cmp_d   = '0;
            state_d = S_WR;
          end else begin
            cmp_d = cmp_q + 1'b1;
          end
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A stall seen at this edge turns the following CMP/WR cycle into a bubble, keeping outputs register-decoded.
    if (state_q != S_IDLE && state_q != S_FIN && state_d != S_FIN) stall_d = MODULE_BUSY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      stall_q <= 1'b0;
      addr_q  <= '0;
      pix_q   <= '0;
      count_q <= '0;
      mask_q  <= '0;
      lane_q  <= '0;
      first_q <= '0;
`ifdef OUTPUT_SEND_MULTI_POOL_EN
      pool_q  <= 1'b0;
      cmp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      lane_q  <= lane_d;
      first_q <= first_d;
`ifdef OUTPUT_SEND_MULTI_POOL_EN
      pool_q  <= pool_d;
      cmp_q   <= cmp_d;
`endif
    end
  end

  assign wr_act         = (state_q == S_WR) && !stall_q;
  assign WADDRX         = addr_q;
  assign WCEBX          = !wr_act;
  assign OUTPUT_EN      = wr_act;
  assign OUTPUT_EN_CTRL = wr_act ? (NUM_CH'(1) << lane_q) : '0;
  assign OUTPUT_BUSY    = (state_q != S_IDLE);
  assign DONE           = (state_q == S_FIN);

`ifdef OUTPUT_SEND_MULTI_POOL_EN
  assign O_COMPARE_EN     = (state_q == S_CMP) && !stall_q;
  assign O_COMPARE_MODE   = O_COMPARE_EN && (cmp_q != '0);
  assign O_COMPARE_SWITCH = pool_q && (state_q == S_WR);
`else
  assign O_COMPARE_EN     = 1'b0;
  assign O_COMPARE_MODE   = 1'b0;
  assign O_COMPARE_SWITCH = 1'b0;
`endif

endmodule

// File: tb/tb_output_send_multi.sv
// tb_output_send_multi: directed and randomized jobs checked cycle by cycle against a
// job-level model (expected compare/write event list plus stall bookkeeping).
module tb_output_send_multi;
  localparam int NUM_CH = 6;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;
  localparam int POOL_K = 4;
`ifdef OUTPUT_SEND_MULTI_POOL_EN
  localparam bit POOL_BUILT = 1'b1;
`else
  localparam bit POOL_BUILT = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              START;
  logic              POOL;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [CNT_W-1:0]  COUNT;
  logic [NUM_CH-1:0] CH_MASK;
  logic              MODULE_BUSY;
  logic [ADDR_W-1:0] WADDRX;
  logic              WCEBX;
  logic              OUTPUT_EN;
  logic [NUM_CH-1:0] OUTPUT_EN_CTRL;
  logic              O_COMPARE_EN;
  logic              O_COMPARE_MODE;
  logic              O_COMPARE_SWITCH;
  logic              OUTPUT_BUSY;
  logic              DONE;

  output_send_multi #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .POOL_K(POOL_K)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .POOL(POOL), .BASE_ADDR(BASE_ADDR),
    .COUNT(COUNT), .CH_MASK(CH_MASK), .MODULE_BUSY(MODULE_BUSY),
    .WADDRX(WADDRX), .WCEBX(WCEBX), .OUTPUT_EN(OUTPUT_EN),
    .OUTPUT_EN_CTRL(OUTPUT_EN_CTRL), .O_COMPARE_EN(O_COMPARE_EN),
    .O_COMPARE_MODE(O_COMPARE_MODE), .O_COMPARE_SWITCH(O_COMPARE_SWITCH),
    .OUTPUT_BUSY(OUTPUT_BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit                is_wr;
    bit                mode;
    logic [ADDR_W-1:0] addr;
    int                lane;
  } ev_t;

  ev_t evq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit wceb, input bit en,
                            input logic [NUM_CH-1:0] ctrl, input bit cmp_en,
                            input bit busy, input bit done);
    check({tag, ".wcebx"}, 32'(WCEBX), 32'(wceb));
    check({tag, ".output_en"}, 32'(OUTPUT_EN), 32'(en));
    check({tag, ".en_ctrl"}, 32'(OUTPUT_EN_CTRL), 32'(ctrl));
    check({tag, ".cmp_en"}, 32'(O_COMPARE_EN), 32'(cmp_en));
    check({tag, ".busy"}, 32'(OUTPUT_BUSY), 32'(busy));
    check({tag, ".done"}, 32'(DONE), 32'(done));
  endtask

  task automatic junk_config();
    POOL      = 1'($urandom);
    BASE_ADDR = ADDR_W'($urandom);
    COUNT     = CNT_W'($urandom);
    CH_MASK   = NUM_CH'($urandom);
  endtask

  // Runs one job from an IDLE negedge; busy_mode 0 = never stall, 1 = random, 2 = stall after cycles 1..3.
  task automatic run_job(input string name, input bit pool, input logic [ADDR_W-1:0] base,
                         input logic [CNT_W-1:0] cnt, input logic [NUM_CH-1:0] mask,
                         input int busy_mode, input int exp_stalls);
    bit                pool_eff;
    bit                stalled;
    bit                b;
    int                cyc;
    int                n_stall;
    int                job_len;
    logic [ADDR_W-1:0] a;
    ev_t               ev;
    string             tag;

    pool_eff = pool && POOL_BUILT;
    evq.delete();
    a = base;
    for (int p = 0; p < int'(cnt); p++) begin
      if (pool_eff)
        for (int k = 0; k < POOL_K; k++) evq.push_back('{1'b0, (k != 0), '0, 0});
      for (int c = 0; c < NUM_CH; c++)
        if (mask[c]) begin
          evq.push_back('{1'b1, 1'b0, a, c});
          a = a + 1'b1;
        end
    end
    job_len = (cnt == 0 || mask == 0) ? 0
            : int'(cnt) * (POOL_K * int'(pool_eff) + $countones(mask));

    START = 1'b1; POOL = pool; BASE_ADDR = base; COUNT = cnt; CH_MASK = mask;
    MODULE_BUSY = 1'($urandom);
    @(negedge CLK);
    START = 1'b0;
    stalled = 1'b0;
    n_stall = 0;
    cyc = 0;
    while (1) begin
      cyc++;
      tag = $sformatf("%s.c%0d", name, cyc);
      if (cyc > 2000) begin
        check({tag, ".timeout"}, 32'd0, 32'd1);
        break;
      end
      if (evq.size() == 0) begin
        check_outs({tag, ".fin"}, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        check({name, ".fin_cycle"}, 32'(cyc), 32'(job_len + n_stall + 1));
        if (exp_stalls >= 0) check({name, ".stalls"}, 32'(n_stall), 32'(exp_stalls));
        break;
      end
      if (stalled) begin
        n_stall++;
        check_outs({tag, ".stall"}, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        check({tag, ".switch"}, 32'(O_COMPARE_SWITCH), 32'(pool_eff && evq[0].is_wr));
      end else begin
        ev = evq.pop_front();
        if (ev.is_wr) begin
          check_outs({tag, ".wr"}, 1'b0, 1'b1, NUM_CH'(1) << ev.lane, 1'b0, 1'b1, 1'b0);
          check({tag, ".addr"}, 32'(WADDRX), 32'(ev.addr));
          check({tag, ".switch"}, 32'(O_COMPARE_SWITCH), 32'(pool_eff));
        end else begin
          check_outs({tag, ".cmp"}, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
          check({tag, ".mode"}, 32'(O_COMPARE_MODE), 32'(ev.mode));
        end
      end
      case (busy_mode)
        1:       b = ($urandom_range(0, 2) == 0);
        2:       b = (cyc >= 1 && cyc <= 3);
        default: b = 1'b0;
      endcase
      MODULE_BUSY = b;
      stalled = b && (evq.size() != 0);
      START = ($urandom_range(0, 4) == 0);
      if (START) junk_config();
      @(negedge CLK);
    end
    // A START during FIN must not be taken; the next cycle has to be IDLE.
    START = 1'($urandom);
    junk_config();
    MODULE_BUSY = 1'($urandom);
    @(negedge CLK);
    check_outs({name, ".idle_after"}, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    START = 1'b0;
    MODULE_BUSY = 1'b0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; POOL = 1'b0; BASE_ADDR = '0; COUNT = '0; CH_MASK = '0;
    MODULE_BUSY = 1'b0;
    #1;
    check_outs("reset", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("reset.waddrx", 32'(WADDRX), 32'd0);
    check("reset.mode", 32'(O_COMPARE_MODE), 32'd0);
    check("reset.switch", 32'(O_COMPARE_SWITCH), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    run_job("nopool", 1'b0, 16'h0100, 8'd2, 6'b000101, 0, 0);
    run_job("pool",   1'b1, 16'h0100, 8'd1, 6'b000011, 0, 0);
    run_job("stall",  1'b0, 16'h0300, 8'd3, 6'b000100, 2, 3);
    run_job("empty_cnt",  1'b1, 16'h0400, 8'd0, 6'b111111, 0, 0);
    run_job("empty_mask", 1'b1, 16'h0400, 8'd3, 6'b000000, 0, 0);
    run_job("wrap",   1'b0, 16'hFFFF, 8'd2, 6'b010000, 0, 0);
    run_job("pool_stall", 1'b1, 16'h1234, 8'd2, 6'b101001, 1, -1);

    // Reset pulsed in the middle of a write burst abandons the job.
    START = 1'b1; POOL = 1'b0; BASE_ADDR = 16'h0200; COUNT = 8'd3; CH_MASK = 6'b000001;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    check("rst_mid.pre_wcebx", 32'(WCEBX), 32'd0);
    check("rst_mid.pre_addr", 32'(WADDRX), 32'h0201);
    RST = 1'b1;
    #1;
    check_outs("rst_mid", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_mid.waddrx", 32'(WADDRX), 32'd0);
    #1 RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_outs($sformatf("rst_after.c%0d", i), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end

    for (int j = 0; j < 40; j++) begin
      logic [CNT_W-1:0]  cnt;
      logic [NUM_CH-1:0] mask;
      cnt  = ($urandom_range(0, 7) == 0) ? '0 : CNT_W'($urandom_range(1, 5));
      mask = NUM_CH'($urandom);
      run_job($sformatf("rand%0d", j), 1'($urandom), ADDR_W'($urandom), cnt, mask, 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
